// File: rtl/mem_arb_pkg.sv
// Shared encodings for the inst/data memory arbiter: source ids,
// access-size constants and the address-phase lock state.
package mem_arb_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Bit 0 of a locked state carries the frozen source id.
    typedef enum logic [1:0] {
        LK_IDLE = 2'b00,
        LK_INST = 2'b10,
        LK_DATA = 2'b11
    } lock_e;

    function automatic lock_e lock_of(input logic src);
        return (src == SRC_DATA) ? LK_DATA : LK_INST;
    endfunction

endpackage

// File: rtl/arb_order_fifo.sv
// In-order source-id FIFO: one bit per outstanding memory transaction.
// Ports: clk, resetn, push/din, pop, full, empty, head (oldest entry).
import mem_arb_pkg::*;

module arb_order_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_MSB = PW'(1) << (PW - 1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic [DEPTH-1:0] mem;
    logic             do_push;
    logic             do_pop;

    generate
        if (DEPTH == 1) begin : g_one
            assign wr_idx = '0;
            assign rd_idx = '0;
        end else begin : g_many
            assign wr_idx = wr_ptr[IW-1:0];
            assign rd_idx = rd_ptr[IW-1:0];
        end
    endgenerate

    assign empty = (wr_ptr == rd_ptr);
    // Wrap bits differ, index bits equal.
    assign full  = ((wr_ptr ^ rd_ptr) == PTR_MSB);
    assign head  = mem[rd_idx];

    // A simultaneous pop frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_idx] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one SRAM-like arbiter: fetch (i_*) and data (d_*) share m_*.
// Ports: i_*/d_* requester sides, m_* memory side, optional perf_*
// counters when MEM_ARBITER_PERF_EN is defined.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_full_stall
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    lock_e      state_q;
    lock_e      state_d;
    logic       sel;
    logic       accept;
    logic [3:0] starve;
    logic       starve_hit;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       pop;

    assign starve_hit = (starve == LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= LK_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        sel     = SRC_INST;
        m_req   = 1'b0;
        state_d = LK_IDLE;
        unique case (state_q)
            LK_INST: begin
                sel   = SRC_INST;
                m_req = 1'b1;
            end
            LK_DATA: begin
                sel   = SRC_DATA;
                m_req = 1'b1;
            end
            default: begin
                m_req = !fifo_full && (i_req || d_req);
                sel   = (d_req && !(i_req && starve_hit))
                        ? SRC_DATA : SRC_INST;
            end
        endcase
        if (m_req && !m_addr_ok) state_d = lock_of(sel);

        m_wr    = (sel == SRC_DATA) ? d_wr    : i_wr;
        m_size  = (sel == SRC_DATA) ? d_size  : i_size;
        m_wstrb = (sel == SRC_DATA) ? d_wstrb : i_wstrb;
        m_addr  = (sel == SRC_DATA) ? d_addr  : i_addr;
        m_wdata = (sel == SRC_DATA) ? d_wdata : i_wdata;
    end

    assign accept    = m_req && m_addr_ok;
    assign i_addr_ok = accept && (sel == SRC_INST);
    assign d_addr_ok = accept && (sel == SRC_DATA);

    // Counts data wins over a waiting fetch; reaching LIMIT flips priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve <= '0;
        end else if (!i_req) begin
            starve <= '0;
        end else if (accept) begin
            if (sel == SRC_INST)  starve <= '0;
            else if (!starve_hit) starve <= starve + 4'd1;
        end
    end

    arb_order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .din    (sel),
        .pop    (pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

    // A stray response with nothing outstanding is dropped.
    assign pop       = m_data_ok && !fifo_empty;
    assign i_data_ok = pop && (fifo_head == SRC_INST);
    assign d_data_ok = pop && (fifo_head == SRC_DATA);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    rsp_needs_outstanding: assert property (
        @(posedge clk) disable iff (!resetn)
        !(m_data_ok && fifo_empty)
    ) else $warning("mem_arbiter: m_data_ok with no outstanding request");

`ifdef MEM_ARBITER_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_i_grants   <= '0;
            perf_d_grants   <= '0;
            perf_full_stall <= '0;
        end else begin
            if (i_addr_ok) perf_i_grants <= perf_i_grants + 32'd1;
            if (d_addr_ok) perf_d_grants <= perf_d_grants + 32'd1;
            if (fifo_full && (i_req || d_req))
                perf_full_stall <= perf_full_stall + 32'd1;
        end
    end
`endif

endmodule
